// File: rtl/l1_defs_pkg.sv
// l1_defs: state encodings, port IDs and widths shared by
// the L1-to-MMU arbiter and its round-robin picker.
package l1_defs;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/l1_arb_pick.sv
// l1_arb_pick: 2-way I/D picker, round-robin on last grant.
// L1ARB_DCACHE_PRIO_EN turns it into fixed D-over-I priority.
module l1_arb_pick
    import l1_defs::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    always_comb begin
        o_valid = i_req_i | i_req_d;
`ifdef L1ARB_DCACHE_PRIO_EN
        o_grant = i_req_d ? PORT_D : PORT_I;
`else
        if (i_req_i && i_req_d) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req_d ? PORT_D : PORT_I;
        end
`endif
    end

endmodule

// File: rtl/l1_arbiter.sv
// l1_arbiter: shares the L1-to-MMU line port between I and D caches.
// Define L1ARB_DCACHE_PRIO_EN for fixed D priority instead of round-robin.
module l1_arbiter
    import l1_defs::*;
(
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              i_req_read,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [LINE_W-1:0] i_write_data,
    output logic              i_read_done,
    output logic              i_write_done,
    output logic [LINE_W-1:0] i_read_data,
    input  logic              d_req_read,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [LINE_W-1:0] d_write_data,
    output logic              d_read_done,
    output logic              d_write_done,
    output logic [LINE_W-1:0] d_read_data,
    output logic              arb_mmu_req_read,
    output logic              arb_mmu_req_write,
    output logic [ADDR_W-1:0] arb_mmu_req_addr,
    output logic [LINE_W-1:0] arb_mmu_write_data,
    input  logic              mmu_arb_read_done,
    input  logic              mmu_arb_write_done,
    input  logic [LINE_W-1:0] mmu_arb_read_data
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_req_read;
    logic              r_req_write;
    logic [ADDR_W-1:0] r_req_addr;
    logic [LINE_W-1:0] r_wdata;

    logic              w_last_grant;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_vld;
    logic              w_pick;
    logic              w_load;
    logic              w_clr;
    logic              w_done_hit;
    logic              w_sel_read;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LINE_W-1:0] w_sel_wdata;
    logic              w_busy_i;
    logic              w_busy_d;

    assign w_i_req = i_req_read | i_req_write;
    assign w_d_req = d_req_read | d_req_write;

    l1_arb_pick u_pick (
        .i_req_i      (w_i_req),
        .i_req_d      (w_d_req),
        .i_last_grant (w_last_grant),
        .o_valid      (w_pick_vld),
        .o_grant      (w_pick)
    );

    assign w_sel_read  = (w_pick == PORT_D) ? d_req_read   : i_req_read;
    assign w_sel_write = (w_pick == PORT_D) ? d_req_write  : i_req_write;
    assign w_sel_addr  = (w_pick == PORT_D) ? d_req_addr   : i_req_addr;
    assign w_sel_wdata = (w_pick == PORT_D) ? d_write_data : i_write_data;

    // Only the done that matches the latched op ends the grant.
    assign w_done_hit = r_req_read ? mmu_arb_read_done : mmu_arb_write_done;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_pick == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_done_hit) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!mmu_arb_read_done && !mmu_arb_write_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_read  <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_req_read  <= w_sel_read;
                r_req_write <= w_sel_write & ~w_sel_read;
                r_req_addr  <= w_sel_addr;
                r_wdata     <= w_sel_wdata;
            end else if (w_clr) begin
                r_req_read  <= 1'b0;
                r_req_write <= 1'b0;
            end
        end
    end

`ifdef L1ARB_DCACHE_PRIO_EN
    assign w_last_grant = PORT_I;
`else
    logic r_last_grant;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_I;
        end else if (w_load) begin
            r_last_grant <= w_pick;
        end
    end

    assign w_last_grant = r_last_grant;
`endif

    assign w_busy_i = (r_state == ST_BUSY_I);
    assign w_busy_d = (r_state == ST_BUSY_D);

    assign i_read_done  = w_busy_i & mmu_arb_read_done;
    assign i_write_done = w_busy_i & mmu_arb_write_done;
    assign i_read_data  = w_busy_i ? mmu_arb_read_data : '0;
    assign d_read_done  = w_busy_d & mmu_arb_read_done;
    assign d_write_done = w_busy_d & mmu_arb_write_done;
    assign d_read_data  = w_busy_d ? mmu_arb_read_data : '0;

    assign arb_mmu_req_read   = r_req_read;
    assign arb_mmu_req_write  = r_req_write;
    assign arb_mmu_req_addr   = r_req_addr;
    assign arb_mmu_write_data = r_wdata;

endmodule

// File: tb/tb_l1_arbiter.sv
// tb_l1_arbiter: directed bench with an MMU model and a
// grant-order scoreboard for the L1-to-MMU arbiter.
module tb_l1_arbiter;

    localparam int LAT = 3;

    logic         sys_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic         i_req_read, i_req_write;
    logic [31:0]  i_req_addr;
    logic [255:0] i_write_data;
    logic         i_read_done, i_write_done;
    logic [255:0] i_read_data;
    logic         d_req_read, d_req_write;
    logic [31:0]  d_req_addr;
    logic [255:0] d_write_data;
    logic         d_read_done, d_write_done;
    logic [255:0] d_read_data;
    logic         arb_mmu_req_read, arb_mmu_req_write;
    logic [31:0]  arb_mmu_req_addr;
    logic [255:0] arb_mmu_write_data;
    logic         mmu_arb_read_done, mmu_arb_write_done;
    logic [255:0] mmu_arb_read_data;

    always #5 sys_clk = ~sys_clk;

    l1_arbiter dut (
        .sys_clk            (sys_clk),
        .rst_n              (rst_n),
        .i_req_read         (i_req_read),
        .i_req_write        (i_req_write),
        .i_req_addr         (i_req_addr),
        .i_write_data       (i_write_data),
        .i_read_done        (i_read_done),
        .i_write_done       (i_write_done),
        .i_read_data        (i_read_data),
        .d_req_read         (d_req_read),
        .d_req_write        (d_req_write),
        .d_req_addr         (d_req_addr),
        .d_write_data       (d_write_data),
        .d_read_done        (d_read_done),
        .d_write_done       (d_write_done),
        .d_read_data        (d_read_data),
        .arb_mmu_req_read   (arb_mmu_req_read),
        .arb_mmu_req_write  (arb_mmu_req_write),
        .arb_mmu_req_addr   (arb_mmu_req_addr),
        .arb_mmu_write_data (arb_mmu_write_data),
        .mmu_arb_read_done  (mmu_arb_read_done),
        .mmu_arb_write_done (mmu_arb_write_done),
        .mmu_arb_read_data  (mmu_arb_read_data)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    bit   ord[$];

    int   n_checks = 0;
    int   n_fail   = 0;

    int   phase      = 0;
    int   cnt        = 0;
    int   hold       = 0;
    int   hold_extra = 0;
    bit   cur_port   = 1'b0;
    bit   raised_now = 1'b0;
    txn_t cur;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic rd, input logic wr,
                                input logic [31:0] a);
        txn_t t;
        t.rd    = rd;
        t.wr    = wr;
        t.addr  = a;
        t.wdata = {8{~a}};
        t.rdata = {8{a ^ 32'hC3C3_0000}};
        return t;
    endfunction

    task automatic drive_port(input bit p);
        if (!p) begin
            if (iq.size() > 0) begin
                i_req_read   = iq[0].rd;
                i_req_write  = iq[0].wr;
                i_req_addr   = iq[0].addr;
                i_write_data = iq[0].wdata;
            end else begin
                i_req_read   = 1'b0;
                i_req_write  = 1'b0;
                i_req_addr   = '0;
                i_write_data = '0;
            end
        end else begin
            if (dq.size() > 0) begin
                d_req_read   = dq[0].rd;
                d_req_write  = dq[0].wr;
                d_req_addr   = dq[0].addr;
                d_write_data = dq[0].wdata;
            end else begin
                d_req_read   = 1'b0;
                d_req_write  = 1'b0;
                d_req_addr   = '0;
                d_write_data = '0;
            end
        end
    endtask

    // MMU model: acts on negedge, LAT cycles of latency, optional done hold.
    task automatic mmu_negedge();
        logic act;
        act        = arb_mmu_req_read | arb_mmu_req_write;
        raised_now = 1'b0;
        case (phase)
            0: if (act) begin
                if (ord.size() == 0 ||
                    (ord[0] ? dq.size() == 0 : iq.size() == 0)) begin
                    chk("unexpected_grant", act, 1'b0);
                end else begin
                    cur_port = ord.pop_front();
                    cur      = cur_port ? dq[0] : iq[0];
                    chk("grant_port_addr", arb_mmu_req_addr, cur.addr);
                    chk("grant_op", {arb_mmu_req_read, arb_mmu_req_write},
                        {cur.rd, ~cur.rd});
                    if (!cur.rd) chk("grant_wdata", arb_mmu_write_data, cur.wdata);
                    cnt   = 0;
                    phase = 1;
                end
            end
            1: if (!act) begin
                phase = 0;
            end else begin
                chk("busy_addr_hold", arb_mmu_req_addr, cur.addr);
                chk("busy_op_hold", {arb_mmu_req_read, arb_mmu_req_write},
                    {cur.rd, ~cur.rd});
                cnt++;
                if (cnt >= LAT) begin
                    if (cur.rd) begin
                        mmu_arb_read_done = 1'b1;
                        mmu_arb_read_data = cur.rdata;
                    end else begin
                        mmu_arb_write_done = 1'b1;
                    end
                    raised_now = 1'b1;
                    hold       = hold_extra;
                    hold_extra = 0;
                    phase      = 2;
                end
            end
            default: begin
                chk("drain_req_low", {arb_mmu_req_read, arb_mmu_req_write}, 2'b00);
                if (hold > 0) begin
                    hold--;
                end else begin
                    mmu_arb_read_done  = 1'b0;
                    mmu_arb_write_done = 1'b0;
                    mmu_arb_read_data  = '0;
                    phase              = 0;
                end
            end
        endcase
    endtask

    task automatic step();
        logic [3:0] exp;
        bit         dv;
        @(negedge sys_clk);
        mmu_negedge();
        #1;
        exp = 4'b0000;
        if (raised_now) begin
            exp = cur_port ? {2'b00, cur.rd, ~cur.rd} : {cur.rd, ~cur.rd, 2'b00};
        end
        chk("req_dones", {i_read_done, i_write_done, d_read_done, d_write_done}, exp);
        if (raised_now && cur.rd) begin
            chk("owner_rdata", cur_port ? d_read_data : i_read_data, cur.rdata);
            chk("other_rdata_zero", cur_port ? i_read_data : d_read_data, 256'd0);
        end
        dv = raised_now;
        @(posedge sys_clk);
        #1;
        if (dv) begin
            if (cur_port) dq.delete(0);
            else          iq.delete(0);
            drive_port(cur_port);
        end
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            step();
            if (ord.size() == 0 && iq.size() == 0 && dq.size() == 0 &&
                phase == 0 && !arb_mmu_req_read && !arb_mmu_req_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_within_budget", ok, 1'b1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        txn_t t;
        drive_port(0);
        drive_port(1);
        mmu_arb_read_done  = 1'b0;
        mmu_arb_write_done = 1'b0;
        mmu_arb_read_data  = '0;

        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_mmu_req", {arb_mmu_req_read, arb_mmu_req_write}, 2'b00);
        chk("rst_mmu_addr", arb_mmu_req_addr, 32'd0);
        chk("rst_mmu_wdata", arb_mmu_write_data, 256'd0);
        chk("rst_dones", {i_read_done, i_write_done, d_read_done, d_write_done}, 4'b0);
        chk("rst_rdata", {i_read_data, d_read_data}, 512'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // single I read
        t       = mk(1'b1, 1'b0, 32'h0000_0040);
        t.rdata = {8{32'hA5A5_A5A5}};
        iq.push_back(t);
        ord.push_back(1'b0);
        drive_port(0);
        step();
        chk("t1_req_read", {arb_mmu_req_read, arb_mmu_req_write}, 2'b10);
        chk("t1_req_addr", arb_mmu_req_addr, 32'h40);
        wait_idle(40);

        // four tie rounds, both ports re-requesting
        iq.push_back(mk(1'b1, 1'b0, 32'h100));
        iq.push_back(mk(1'b1, 1'b0, 32'h140));
        dq.push_back(mk(1'b0, 1'b1, 32'h200));
        dq.push_back(mk(1'b0, 1'b1, 32'h240));
`ifdef L1ARB_DCACHE_PRIO_EN
        ord.push_back(1'b1); ord.push_back(1'b1);
        ord.push_back(1'b0); ord.push_back(1'b0);
`else
        ord.push_back(1'b1); ord.push_back(1'b0);
        ord.push_back(1'b1); ord.push_back(1'b0);
`endif
        drive_port(0);
        drive_port(1);
        wait_idle(100);

        // read and write together: read wins
        iq.push_back(mk(1'b1, 1'b1, 32'h80));
        ord.push_back(1'b0);
        drive_port(0);
        wait_idle(40);

        // MMU holds done 3 extra cycles; D waits behind DRAIN
        hold_extra = 3;
        iq.push_back(mk(1'b1, 1'b0, 32'hC0));
        ord.push_back(1'b0);
        drive_port(0);
        step();
        step();
        dq.push_back(mk(1'b1, 1'b0, 32'h400));
        ord.push_back(1'b1);
        drive_port(1);
        wait_idle(60);

        // requester address change mid-grant
        dq.push_back(mk(1'b0, 1'b1, 32'h200));
        ord.push_back(1'b1);
        drive_port(1);
        step();
        step();
        d_req_addr = 32'h300;
        step();
        chk("t5_addr_hold", arb_mmu_req_addr, 32'h200);
        wait_idle(40);

        // async reset mid BUSY_D write
        dq.push_back(mk(1'b0, 1'b1, 32'h500));
        ord.push_back(1'b1);
        drive_port(1);
        step();
        step();
        chk("t6_busy_write", arb_mmu_req_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", {arb_mmu_req_read, arb_mmu_req_write}, 2'b00);
        dq.delete(0);
        drive_port(1);
        step();
        #2;
        rst_n = 1'b1;
        iq.push_back(mk(1'b1, 1'b0, 32'h700));
        dq.push_back(mk(1'b1, 1'b0, 32'h600));
        ord.push_back(1'b1);
        ord.push_back(1'b0);
        drive_port(0);
        drive_port(1);
        wait_idle(80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_arbiter.md
# l1_arbiter

Two-port arbiter that shares the single L1-to-MMU refill/writeback port between the instruction cache (port I) and the data cache (port D). It sits between both L1 caches and `l1mmu`. It registers one requester's 256-bit line transaction, holds it stable until the MMU signals done, and routes the done and read data back to the granted requester only. It then drains the MMU handshake before the next grant.

## Interface
- No parameters.
- `sys_clk` in 1: system clock; arbiter logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req_read`, `i_req_write` in 1 each: port I requests, held level until done.
- `i_req_addr` in 32: port I line address.
- `i_write_data` in 256: port I writeback line.
- `i_read_done`, `i_write_done` out 1 each: port I completion.
- `i_read_data` out 256: port I refill line.
- `d_req_read`, `d_req_write`, `d_req_addr`, `d_write_data`, `d_read_done`, `d_write_done`, `d_read_data`: port D, same widths and semantics as port I.
- `arb_mmu_req_read`, `arb_mmu_req_write` out 1 each: registered request to the MMU.
- `arb_mmu_req_addr` out 32: registered MMU address.
- `arb_mmu_write_data` out 256: registered MMU write line.
- `mmu_arb_read_done`, `mmu_arb_write_done` in 1 each: MMU completion; the MMU updates these on negedge.
- `mmu_arb_read_data` in 256: MMU read line.

## Operation
- States:
  - IDLE: no grant.
  - BUSY_I / BUSY_D: transaction owned by the named port.
  - DRAIN: request dropped; waiting for MMU done lines to clear.
- IDLE transitions:
  - At a posedge with any request pending, pick a winner.
  - Latch the winner's addr, write data and op into the `arb_mmu_*` registers, then go to BUSY_x.
  - With no request pending, stay in IDLE.
- Op selection: if a port asserts read and write together, read wins and write is ignored for that grant. Exactly one of `arb_mmu_req_read` / `arb_mmu_req_write` is high while BUSY.
- Arbitration is round-robin. A `last_grant` bit records the most recent winner. When both ports request in IDLE, the port that did not win last is granted. After reset, `last_grant` = I, so D wins the first tie.
- BUSY_x:
  - The latched request is held constant; requester input changes are ignored.
  - Done routing: `x_read_done = mmu_arb_read_done`, `x_write_done = mmu_arb_write_done`, `x_read_data = mmu_arb_read_data`, combinationally gated by state.
  - The non-granted port's dones are 0 and its data is 0.
  - At a posedge where the done matching the latched op is high, clear the `arb_mmu_*` request bits and go to DRAIN.
- DRAIN:
  - All requester dones are forced to 0.
  - Stay until both `mmu_arb_read_done` and `mmu_arb_write_done` are low at a posedge, then go to IDLE.
  - This prevents the MMU's stale done from gating a new transaction.
- Requester obligation: drop its request at the posedge where it samples its done high.
  - A port still requesting in IDLE is treated as a new transaction, which is legal.

## Timing
- Reset values: state IDLE, `last_grant` I, all `arb_mmu_*` outputs 0, all requester dones 0, all requester read data 0.
- Request in IDLE at posedge N: `arb_mmu_req_*` valid after posedge N.
- MMU done, which rises on a negedge, is visible to the requester in the same half-cycle. The arbiter consumes it at the following posedge M.
- MMU request low after posedge M. DRAIN lasts at least 1 cycle; IDLE is reached no earlier than M+1.
- Minimum turnaround between two grants: request edge + MMU latency + 2 cycles.
- A requester asserting during BUSY or DRAIN waits; its request is evaluated only in IDLE.
- Asynchronous reset mid-BUSY: MMU request outputs drop immediately and the state returns to IDLE. The MMU sees the request fall and self-resets to its idle state.

## Configuration
- `L1ARB_DCACHE_PRIO_EN`:
  - Defined: fixed priority; D always wins a tie and `last_grant` is not implemented.
  - Undefined (default): round-robin as above.

## Structure
- Shared package/header `l1_defs`: state encodings (IDLE/BUSY_I/BUSY_D/DRAIN), port-ID constants (PORT_I=0, PORT_D=1), line width 256, address width 32.
- Sub-module `l1_arb_pick`: 2-way round-robin picker, combinational, with `last_grant` input. Under `L1ARB_DCACHE_PRIO_EN` it degenerates to fixed priority.

## Test plan
- Single I read at addr 0x0000_0040: `arb_mmu_req_read`=1 with addr 0x40 after one posedge. MMU done with data {8{0xA5A5A5A5}} → `i_read_done`=1 with the same data; `d_read_done` stays 0.
- Simultaneous I read at 0x100 and D write at 0x200 after reset: D is granted first. I is granted after D's DRAIN. `last_grant` alternates over 4 back-to-back tie rounds: D,I,D,I. With `L1ARB_DCACHE_PRIO_EN` the sequence is D,D,D,D while D keeps requesting.
- I asserts read and write together: only `arb_mmu_req_read`=1; `i_write_done` never asserts.
- MMU holds done high for 3 extra cycles after the request drops: arbiter stays in DRAIN for those cycles. A pending D request is not granted until done is low; no requester sees a spurious done.
- Requester changes `d_req_addr` from 0x200 to 0x300 mid-BUSY: `arb_mmu_req_addr` stays 0x200 until completion.
- `rst_n` pulsed low mid-BUSY_D write: `arb_mmu_req_write` falls asynchronously. State is IDLE after release, and the next request is granted normally.
